cot_gate_drive: RTL

//  Consumes the set/reset pulse pair of the constant-on-time loop and drives the buck half-bridge.
//  A rising edge on set turns the high side on; a reset_pwm pulse from the on-time timer turns it off.

---
 rtl/cot_gate_drive.sv | 97 +++++++++
 1 files changed

// File: rtl/cot_gate_drive.sv
// Constant-on-time half-bridge gate driver: dead time, min off,
// max on and abort handling between the ton timer and gate pins.
module cot_gate_drive #(
  parameter int DEADTIME = 8,
  parameter int MIN_OFF  = 20,
  parameter int MAX_ON   = 4000,
  parameter int CNT_W    = 21
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic fault,
  input  logic set,
  input  logic reset_pwm,
  output logic hs_gate,
  output logic ls_gate,
  output logic on_active,
  output logic max_on_err
);

  typedef enum logic [2:0] {
    S_OFF = 3'd0,
    S_LS  = 3'd1,
    S_DTR = 3'd2,
    S_HS  = 3'd3,
    S_DTF = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DT_LAST  = CNT_W'(DEADTIME - 1);
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_OFF);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_ON - 1);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic             set_dly;
  logic             set_pos;
  logic             abort;
  logic             max_hit;

  assign set_pos = set & ~set_dly;
  assign abort   = ~en | fault;

  always_comb begin
    nxt     = state;
    max_hit = 1'b0;
    if (abort) begin
      nxt = S_OFF;
    end else begin
      unique case (state)
        S_OFF: nxt = S_LS;
        S_LS: begin
          if (set_pos && cnt >= MIN_CNT) nxt = S_DTR;
        end
        S_DTR: begin
          if (cnt == DT_LAST) nxt = S_HS;
        end
        S_HS: begin
          // a timer turn-off on the expiry cycle is not an error
          if (reset_pwm) begin
            nxt = S_DTF;
          end else if (cnt == MAX_LAST) begin
            nxt     = S_DTF;
            max_hit = 1'b1;
          end
        end
        S_DTF: begin
          if (cnt == DT_LAST) nxt = S_LS;
        end
        default: nxt = S_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_OFF;
      cnt        <= '0;
      set_dly    <= 1'b0;
      hs_gate    <= 1'b0;
      ls_gate    <= 1'b0;
      on_active  <= 1'b0;
      max_on_err <= 1'b0;
    end else begin
      state   <= nxt;
      set_dly <= set;
      if (nxt != state) cnt <= '0;
      else if (~&cnt)   cnt <= cnt + 1'b1;
      // gates decode the next state so they move with it
      hs_gate    <= (nxt == S_HS);
      ls_gate    <= (nxt == S_LS);
      on_active  <= (nxt == S_DTR) || (nxt == S_HS);
      max_on_err <= max_hit;
    end
  end

endmodule
